uart_rx_frontend: RTL and testbench

// - Serial receive front end for the bus: converts the asynchronous Rx_Serial line (8N1, LSB first) into bytes.
// - Presents each byte in a one-entry holding register with a valid/ack handshake toward the bus peripheral logic.
// - Sits directly upstream of the bus UART data/status registers; the bus reads rx_data and pulses rx_ack.

---
 rtl/uart_rx_frontend_if.sv | 27 ++
 rtl/uart_rx_frontend.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frontend_if.sv
// Bus-side handshake bundle between the serial receive front end and the
// peripheral register logic that consumes received bytes.
//   rx_ack       bus -> frontend : 1-cycle "byte consumed" pulse
//   rx_data      frontend -> bus : last received byte
//   rx_valid     frontend -> bus : holding register full
//   rx_frame_err frontend -> bus : 1-cycle pulse on a low stop bit
//   rx_overrun   frontend -> bus : sticky, byte overwritten before ack
//   rx_busy      frontend -> bus : receiver not idle
// Modport master is taken by the receiver, slave by the bus peripheral.
interface uart_rx_frontend_if;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_busy;

   modport master (
      input  rx_ack,
      output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
   );

   modport slave (
      output rx_ack,
      input  rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
   );
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 LSB-first serial receiver with a one-entry holding register.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   Rx_Serial  raw serial line, idles high
//   bus        uart_rx_frontend_if.master (rx_ack in; rx_data, rx_valid,
//              rx_frame_err, rx_overrun, rx_busy out)
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit (8..65535)
//   SYNC_STAGES   synchroniser depth (2..3)
module uart_rx_frontend #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Rx_Serial,
   uart_rx_frontend_if.master   bus
);

   localparam logic [15:0] HALF_TC = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] BIT_TC  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;

   state_t                 state_reg, state_next;
   logic [15:0]            baud_reg, baud_next;
   logic [2:0]             bit_reg, bit_next;
   logic [7:0]             shift_reg, shift_next;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic [SYNC_STAGES:0]   prime_reg;
   logic                   prev_reg;
   logic [7:0]             data_reg;
   logic                   valid_reg;
   logic                   ferr_reg;
   logic                   ovr_reg;
   logic                   rx_s;
   logic                   fall;
   logic                   load;
   logic                   ferr_next;

   assign rx_s = sync_reg[SYNC_STAGES-1];

   // The synchroniser resets to 1, so a line that is already low at reset
   // release would look like a 1->0 edge once it flushes through. prime_reg
   // fills with ones one stage per cycle; only when it is full does prev_reg
   // hold a genuinely sampled line value, and only then is an edge accepted.
   assign fall = prime_reg[SYNC_STAGES] & prev_reg & ~rx_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_reg  <= '1;
         prime_reg <= '0;
         prev_reg  <= 1'b1;
      end else begin
         sync_reg  <= {sync_reg[SYNC_STAGES-2:0], Rx_Serial};
         prime_reg <= {prime_reg[SYNC_STAGES-1:0], 1'b1};
         prev_reg  <= rx_s;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      load       = 1'b0;
      ferr_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (fall) begin
               state_next = START;
               baud_next  = '0;
            end
         end
         START: begin
            // Half-bit wait lands the sample in the middle of the start bit;
            // a line already back high means it was only a glitch.
            if (baud_reg == HALF_TC) begin
               baud_next = '0;
               bit_next  = '0;
               state_next = rx_s ? IDLE : DATA;
            end else begin
               baud_next = baud_reg + 16'd1;
            end
         end
         DATA: begin
            if (baud_reg == BIT_TC) begin
               baud_next           = '0;
               shift_next[bit_reg] = rx_s;
               if (bit_reg == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_next = bit_reg + 3'd1;
               end
            end else begin
               baud_next = baud_reg + 16'd1;
            end
         end
         STOP: begin
            if (baud_reg == BIT_TC) begin
               baud_next = '0;
               if (rx_s) begin
                  load       = 1'b1;
                  state_next = IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = BREAK_WAIT;
               end
            end else begin
               baud_next = baud_reg + 16'd1;
            end
         end
         BREAK_WAIT: begin
            // Parks here until the line returns high so a held-low line
            // reports only one framing error.
            if (rx_s) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Holding register and status. An ack in the load cycle absorbs the old
   // byte, so only a load without ack onto a full register is an overrun;
   // that new overrun takes precedence over the clearing effect of an ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg  <= '0;
         valid_reg <= 1'b0;
         ferr_reg  <= 1'b0;
         ovr_reg   <= 1'b0;
      end else begin
         ferr_reg <= ferr_next;
         if (load) begin
            data_reg  <= shift_reg;
            valid_reg <= 1'b1;
         end else if (bus.rx_ack) begin
            valid_reg <= 1'b0;
         end
         if (load && valid_reg && !bus.rx_ack) begin
            ovr_reg <= 1'b1;
         end else if (bus.rx_ack) begin
            ovr_reg <= 1'b0;
         end
      end
   end

   assign bus.rx_data      = data_reg;
   assign bus.rx_valid     = valid_reg;
   assign bus.rx_frame_err = ferr_reg;
   assign bus.rx_overrun   = ovr_reg;
   assign bus.rx_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend (CLKS_PER_BIT=16, SYNC_STAGES=2).
// Stimulus pushes the expected post-event state into a queue; a monitor on
// the falling clock edge pops and compares when the receiver returns to idle
// (frame, glitch or break end) or when an ack has been consumed.
module tb_uart_rx_frontend;
   localparam int CLKS = 16;
   localparam int SYNC = 2;

   typedef struct {
      bit         is_ack;
      int         exp_cyc;
      bit         exp_valid;
      logic [7:0] exp_data;
      bit         exp_ovr;
      int         exp_ferr;
      int         exp_ferr_cyc;
   } exp_t;

   logic clk;
   logic reset;
   logic rx_line;
   int   cyc;
   int   chk_cnt;
   int   pass_cnt;
   int   ev_cnt;
   exp_t q[$];

   // reference model of the bus-visible holding register
   bit         m_valid;
   logic [7:0] m_data;
   bit         m_ovr;

   uart_rx_frontend_if bus();

   uart_rx_frontend #(.CLKS_PER_BIT(CLKS), .SYNC_STAGES(SYNC)) dut (
      .clk       (clk),
      .reset     (reset),
      .Rx_Serial (rx_line),
      .bus       (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // A line change driven just after edge k is first captured at edge k+1;
   // the receiver's line-to-load latency counts from that capture edge.
   function automatic int load_cyc(input int k);
      return k + 1 + SYNC + CLKS / 2 + 9 * CLKS;
   endfunction

   task automatic send_frame(input logic [7:0] b, input bit ack_on_load);
      exp_t e;
      int   k;
      k = cyc;
      if (ack_on_load)  m_ovr = 1'b0;
      else if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = b;
      e.is_ack = 1'b0; e.exp_cyc = load_cyc(k); e.exp_valid = m_valid;
      e.exp_data = m_data; e.exp_ovr = m_ovr; e.exp_ferr = 0; e.exp_ferr_cyc = 0;
      q.push_back(e);
      rx_line = 1'b0;
      tick(CLKS);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         tick(CLKS);
      end
      rx_line = 1'b1;
      if (ack_on_load) begin
         tick(load_cyc(k) - 1 - cyc);
         bus.rx_ack = 1'b1;
         tick(1);
         bus.rx_ack = 1'b0;
         tick(k + 10 * CLKS - cyc);
      end else begin
         tick(CLKS);
      end
   endtask

   task automatic send_bad(input logic [7:0] b, input int hold);
      exp_t e;
      int   k;
      k = cyc;
      e.is_ack = 1'b0; e.exp_valid = m_valid; e.exp_data = m_data; e.exp_ovr = m_ovr;
      e.exp_ferr = 1; e.exp_ferr_cyc = load_cyc(k);
      e.exp_cyc = k + 10 * CLKS + hold + 1 + SYNC;
      q.push_back(e);
      rx_line = 1'b0;
      tick(CLKS);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         tick(CLKS);
      end
      rx_line = 1'b0;
      tick(CLKS + hold);
      rx_line = 1'b1;
      tick(8);
   endtask

   task automatic send_glitch(input int w);
      exp_t e;
      int   k;
      k = cyc;
      e.is_ack = 1'b0; e.exp_cyc = k + 1 + SYNC + CLKS / 2; e.exp_valid = m_valid;
      e.exp_data = m_data; e.exp_ovr = m_ovr; e.exp_ferr = 0; e.exp_ferr_cyc = 0;
      q.push_back(e);
      rx_line = 1'b0;
      tick(w);
      rx_line = 1'b1;
      tick(CLKS);
   endtask

   task automatic do_ack();
      exp_t e;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      e.is_ack = 1'b1; e.exp_cyc = cyc + 1; e.exp_valid = 1'b0;
      e.exp_data = m_data; e.exp_ovr = 1'b0; e.exp_ferr = 0; e.exp_ferr_cyc = 0;
      q.push_back(e);
      bus.rx_ack = 1'b1;
      tick(1);
      bus.rx_ack = 1'b0;
      tick(2);
   endtask

   // monitor / scoreboard
   initial begin
      bit   prev_busy;
      bit   ack_pend;
      int   ferr_cnt;
      int   ferr_cyc;
      exp_t e;
      prev_busy = 1'b0; ack_pend = 1'b0; ferr_cnt = 0; ferr_cyc = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_busy = 1'b0; ack_pend = 1'b0; ferr_cnt = 0;
         end else begin
            if (bus.rx_frame_err) begin
               ferr_cnt++;
               ferr_cyc = cyc;
            end
            if (prev_busy && !bus.rx_busy) begin
               ev_cnt++;
               if (q.size() == 0) begin
                  chk("unexpected_idle_event_queue_size", 0, 1);
               end else begin
                  e = q.pop_front();
                  chk("event_order_is_frame", int'(e.is_ack), 0);
                  chk("idle_return_cycle", cyc, e.exp_cyc);
                  chk("rx_valid", int'(bus.rx_valid), int'(e.exp_valid));
                  chk("rx_data", int'(bus.rx_data), int'(e.exp_data));
                  chk("rx_overrun", int'(bus.rx_overrun), int'(e.exp_ovr));
                  chk("frame_err_pulses", ferr_cnt, e.exp_ferr);
                  if (e.exp_ferr != 0 && ferr_cnt != 0)
                     chk("frame_err_cycle", ferr_cyc, e.exp_ferr_cyc);
                  $display("event %0d: idle at cycle %0d data=0x%02h valid=%0d ovr=%0d ferr=%0d",
                           ev_cnt, cyc, bus.rx_data, bus.rx_valid, bus.rx_overrun, ferr_cnt);
               end
               ferr_cnt = 0;
               ack_pend = 1'b0;
            end else if (ack_pend) begin
               ev_cnt++;
               ack_pend = 1'b0;
               if (q.size() == 0) begin
                  chk("unexpected_ack_event_queue_size", 0, 1);
               end else begin
                  e = q.pop_front();
                  chk("event_order_is_ack", int'(e.is_ack), 1);
                  chk("ack_rx_valid", int'(bus.rx_valid), int'(e.exp_valid));
                  chk("ack_rx_overrun", int'(bus.rx_overrun), int'(e.exp_ovr));
                  chk("ack_rx_data_kept", int'(bus.rx_data), int'(e.exp_data));
                  $display("event %0d: ack consumed at cycle %0d data=0x%02h valid=%0d ovr=%0d",
                           ev_cnt, cyc, bus.rx_data, bus.rx_valid, bus.rx_overrun);
               end
            end
            if (bus.rx_ack) ack_pend = 1'b1;
            prev_busy = bus.rx_busy;
         end
      end
   end

   // stimulus
   initial begin
      bit any_busy;
      chk_cnt = 0; pass_cnt = 0; ev_cnt = 0;
      m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0;
      reset = 1'b1;
      rx_line = 1'b1;
      bus.rx_ack = 1'b0;
      @(negedge clk);
      chk("reset_rx_data", int'(bus.rx_data), 0);
      chk("reset_rx_valid", int'(bus.rx_valid), 0);
      chk("reset_rx_frame_err", int'(bus.rx_frame_err), 0);
      chk("reset_rx_overrun", int'(bus.rx_overrun), 0);
      chk("reset_rx_busy", int'(bus.rx_busy), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick(5);

      send_frame(8'hA5, 1'b0);
      do_ack();
      send_frame(8'h3C, 1'b0);
      do_ack();
      send_frame(8'hC3, 1'b0);
      do_ack();
      send_frame(8'h11, 1'b0);
      send_frame(8'h22, 1'b0);
      do_ack();
      send_frame(8'h11, 1'b0);
      send_frame(8'h22, 1'b1);
      do_ack();
      send_glitch(5);
      send_bad(8'h55, 100);
      send_frame(8'h0F, 1'b0);
      do_ack();

      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            send_glitch(int'($urandom_range(1, 6)));
         end else begin
            send_frame(8'($urandom), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) do_ack();
         end
         tick(int'($urandom_range(0, 20)));
      end

      // full register plus overrun, then reset in the middle of bit 4 of 0xFF
      send_frame(8'h5A, 1'b0);
      send_frame(8'hA6, 1'b0);
      rx_line = 1'b0;
      tick(CLKS);
      for (int i = 0; i < 4; i++) begin
         rx_line = 1'b1;
         tick(CLKS);
      end
      rx_line = 1'b1;
      tick(CLKS / 2);
      chk("pre_reset_rx_valid", int'(bus.rx_valid), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_rx_data", int'(bus.rx_data), 0);
      chk("async_reset_rx_valid", int'(bus.rx_valid), 0);
      chk("async_reset_rx_frame_err", int'(bus.rx_frame_err), 0);
      chk("async_reset_rx_overrun", int'(bus.rx_overrun), 0);
      chk("async_reset_rx_busy", int'(bus.rx_busy), 0);
      m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0;
      rx_line = 1'b0;
      tick(3);
      reset = 1'b0;
      any_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         any_busy = any_busy | bus.rx_busy;
      end
      chk("low_line_at_release_not_start", int'(any_busy), 0);
      rx_line = 1'b1;
      tick(10);
      send_frame(8'h81, 1'b0);
      do_ack();

      tick(300);
      chk("scoreboard_drained", q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
